anita3_trigger_arbiter: RTL
===========================

Name: anita3_trigger_arbiter

Overview:
Sequences trigger issue to the digitizer for all trigger sources: the RF coincidence trigger, the software trigger, PPS and the external trigger. Arbitrates simultaneous requests, enforces a post-trigger holdoff, and tracks digitizer buffer occupancy with a clear handshake. Drops and counts requests that arrive while disabled, in holdoff, or with all buffers full. Sits between the trigger-generation blocks and the SURF readout interface in the clk250 domain.

Parameters:
NUM_SRC, 4, number of trigger request sources; index 0 is the RF trigger.
NUM_BUF, 4, number of digitizer buffers; must be a power of 2, at least 2.
HOLDOFF, 32, holdoff length in clk250 cycles after each issued trigger (32 = 128 ns); at least 1.
CNT_W, 16, width of the event and lost counters.

Ports:
clk250_i  in  1  250 MHz clock; all logic on its rising edge.
rst_i  in  1  reset, asynchronous, active-high.
req_i  in  NUM_SRC  trigger request pulses, one cycle wide per request.
src_mask_i  in  NUM_SRC  1 = source ignored entirely; not counted as lost.
disable_i  in  1  1 = no triggers issued.
clear_i  in  1  one-cycle pulse from readout: one buffer has been released.
trig_o  out  1  one-cycle trigger pulse.
trig_src_o  out  log2(NUM_SRC)  index of the granted source; valid while trig_o=1.
trig_pat_o  out  NUM_SRC  all unmasked requests present in the grant cycle; valid while trig_o=1.
buf_o  out  log2(NUM_BUF)  buffer index assigned to this trigger; valid while trig_o=1.
busy_o  out  1  occupancy equals NUM_BUF.
occ_o  out  log2(NUM_BUF)+1  current buffer occupancy.
event_count_o  out  CNT_W  issued triggers; wraps.
lost_count_o  out  CNT_W  dropped requests; saturates at all ones.
clear_err_o  out  1  sticky flag: clear_i received while occupancy was 0.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; buffer write pointer 0; round-robin pointer 0.
- Definitions:
  - v = req_i & ~src_mask_i.
  - A cycle is eligible when the FSM is in IDLE, disable_i=0, busy_o=0, and v is non-zero.
- Eligible cycle n:
  - Grant the source in v with the lowest index.
  - Cycle n+1: trig_o=1; trig_src_o = granted index; trig_pat_o = v; buf_o = write pointer.
  - Write pointer increments modulo NUM_BUF; occupancy +1; event_count +1.
  - FSM goes to HOLD.
- HOLD:
  - Down-counter loads HOLDOFF-1 on entry and returns to IDLE when it reaches 0.
  - Total non-IDLE time is HOLDOFF cycles counted from the trig_o cycle; the next trig_o comes at the earliest HOLDOFF+1 cycles after the previous one.
- Lost requests:
  - In any cycle where v is non-zero but the cycle is not eligible (HOLD, disabled, or busy), lost_count increases by popcount(v), saturating.
  - In a grant cycle, the requests that were not granted are not counted as lost; they are reported in trig_pat_o.
- Occupancy:
  - issue only: +1.
  - clear_i only, occupancy > 0: -1.
  - issue and clear_i in the same cycle: occupancy unchanged.
  - clear_i with occupancy 0: occupancy stays 0; clear_err_o is set and cleared only by reset.
- busy_o and occ_o are registered from the updated occupancy.
- A clear_i in the cycle where busy_o=1 permits a grant in the next cycle.
- disable_i or busy_o asserted during HOLD has no effect on the holdoff count.
- Asynchronous reset mid-operation: all outputs and state return to reset values immediately. A trig_o in flight is aborted. Counters clear.

Optional Feature:
TRIG_ARB_ROUNDROBIN_EN
- Defined: grant priority rotates. The search over v starts at rr_ptr and wraps; after each grant, rr_ptr = (granted+1) mod NUM_SRC.
- Not defined: fixed priority, lowest index wins; no rr_ptr register exists.

Test Plan:
- After reset, single req_i=0001 -> trig_o one cycle later with trig_src_o=0, trig_pat_o=0001, buf_o=0; occ_o=1; event_count_o=1.
- req_i=0001 at cycle 0 and again at cycles 5 and 32 (HOLDOFF=32) -> only one trig_o, at cycle 1; lost_count_o=2; request at cycle 33 -> trig_o at cycle 34.
- Simultaneous req_i=1010 -> trig_src_o=1, trig_pat_o=1010, lost_count_o unchanged. With TRIG_ARB_ROUNDROBIN_EN, a repeat of 1010 after the holdoff -> trig_src_o=3.
- 4 triggers with no clears -> buf_o sequence 0,1,2,3, busy_o=1. A 5th request -> no trig_o, lost +1. clear_i, then a request -> trig_o with buf_o=0.
- clear_i coincident with issue at occ=2 -> occ stays 2. clear_i at occ=0 -> occ 0, clear_err_o=1.
- disable_i=1 with req_i=1111 -> no trig_o, lost +4. Masked source requesting -> nothing. rst_i pulse mid-HOLD -> all outputs 0, next request issues normally.

Source files
------------

// File: rtl/anita3_trigger_arbiter.sv
// Trigger arbiter for the ANITA-3 digitizer: grants one source per holdoff window and tracks buffer occupancy.
// Optional build macro TRIG_ARB_ROUNDROBIN_EN selects rotating grant priority instead of fixed lowest-index priority.
module anita3_trigger_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int NUM_BUF = 4,
    parameter int HOLDOFF = 32,
    parameter int CNT_W   = 16
) (
    input  logic                       clk250_i,
    input  logic                       rst_i,
    input  logic [NUM_SRC-1:0]         req_i,
    input  logic [NUM_SRC-1:0]         src_mask_i,
    input  logic                       disable_i,
    input  logic                       clear_i,
    output logic                       trig_o,
    output logic [$clog2(NUM_SRC)-1:0] trig_src_o,
    output logic [NUM_SRC-1:0]         trig_pat_o,
    output logic [$clog2(NUM_BUF)-1:0] buf_o,
    output logic                       busy_o,
    output logic [$clog2(NUM_BUF):0]   occ_o,
    output logic [CNT_W-1:0]           event_count_o,
    output logic [CNT_W-1:0]           lost_count_o,
    output logic                       clear_err_o
);

    localparam int SRC_W  = $clog2(NUM_SRC);
    localparam int BUF_W  = $clog2(NUM_BUF);
    localparam int OCC_W  = BUF_W + 1;
    localparam int HCNT_W = $clog2(HOLDOFF + 1);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [HCNT_W-1:0]   r_hcnt;

    logic                r_trig;
    logic [SRC_W-1:0]    r_trig_src;
    logic [NUM_SRC-1:0]  r_trig_pat;
    logic [BUF_W-1:0]    r_buf;
    logic [BUF_W-1:0]    r_wr_ptr;
    logic [OCC_W-1:0]    r_occ;
    logic                r_busy;
    logic [CNT_W-1:0]    r_event_count;
    logic [CNT_W-1:0]    r_lost_count;
    logic                r_clear_err;
`ifdef TRIG_ARB_ROUNDROBIN_EN
    logic [SRC_W-1:0]    r_rr_ptr;
    logic [SRC_W:0]      w_sum;
`endif

    logic [NUM_SRC-1:0]  w_v;
    logic                w_issue;
    logic                w_lost;
    logic                w_found;
    logic [SRC_W-1:0]    w_cand;
    logic [SRC_W-1:0]    w_grant_idx;
    logic [CNT_W:0]      w_pop;
    logic [CNT_W:0]      w_lost_sum;
    logic [OCC_W-1:0]    w_occ_nxt;
    logic                w_clear_err_nxt;

    assign w_v     = req_i & ~src_mask_i;
    assign w_issue = (r_state == IDLE) && !disable_i && !r_busy && (|w_v);
    assign w_lost  = (|w_v) && !w_issue;

    // Priority search; with rotation enabled it starts at r_rr_ptr and wraps.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch can be inferred.
        w_found     = 1'b0;
        w_cand      = '0;
        w_grant_idx = '0;
`ifdef TRIG_ARB_ROUNDROBIN_EN
        w_sum       = '0;
`endif
        for (int k = 0; k < NUM_SRC; k++) begin
`ifdef TRIG_ARB_ROUNDROBIN_EN
            w_sum = {1'b0, r_rr_ptr} + (SRC_W+1)'(k);
            if (w_sum >= (SRC_W+1)'(NUM_SRC))
                w_sum = w_sum - (SRC_W+1)'(NUM_SRC);
            w_cand = w_sum[SRC_W-1:0];
`else
            w_cand = SRC_W'(k);
`endif
            if (!w_found && w_v[w_cand]) begin
                w_found     = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NUM_SRC; i++)
            w_pop = w_pop + {{CNT_W{1'b0}}, w_v[i]};
        w_lost_sum = {1'b0, r_lost_count} + w_pop;
    end

    // A clear that coincides with an issue cancels it; a clear on an empty pool is an error.
    always_comb begin
        w_occ_nxt       = r_occ;
        w_clear_err_nxt = r_clear_err;
        unique case ({w_issue, clear_i})
            2'b10: w_occ_nxt = r_occ + OCC_W'(1);
            2'b01: begin
                if (r_occ != '0)
                    w_occ_nxt = r_occ - OCC_W'(1);
                else
                    w_clear_err_nxt = 1'b1;
            end
            default: w_occ_nxt = r_occ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_issue) w_state_nxt = HOLD;
            HOLD:    if (r_hcnt == '0) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk250_i or posedge rst_i) begin
        // NOTE: clocked state uses non-blocking '<=' so every register samples pre-edge values.
        if (rst_i) begin
            r_state <= IDLE;
            r_hcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue)
                r_hcnt <= HCNT_W'(HOLDOFF - 1);
            else if (r_state == HOLD && r_hcnt != '0)
                r_hcnt <= r_hcnt - HCNT_W'(1);
        end
    end

    always_ff @(posedge clk250_i or posedge rst_i) begin
        if (rst_i) begin
            r_trig        <= 1'b0;
            r_trig_src    <= '0;
            r_trig_pat    <= '0;
            r_buf         <= '0;
            r_wr_ptr      <= '0;
            r_occ         <= '0;
            r_busy        <= 1'b0;
            r_event_count <= '0;
            r_lost_count  <= '0;
            r_clear_err   <= 1'b0;
        end else begin
            r_trig      <= w_issue;
            r_trig_src  <= w_issue ? w_grant_idx : '0;
            r_trig_pat  <= w_issue ? w_v : '0;
            r_buf       <= w_issue ? r_wr_ptr : '0;
            r_occ       <= w_occ_nxt;
            r_busy      <= (w_occ_nxt == OCC_W'(NUM_BUF));
            r_clear_err <= w_clear_err_nxt;
            if (w_issue) begin
                r_wr_ptr      <= r_wr_ptr + BUF_W'(1);
                r_event_count <= r_event_count + CNT_W'(1);
            end
            if (w_lost)
                r_lost_count <= w_lost_sum[CNT_W] ? {CNT_W{1'b1}} : w_lost_sum[CNT_W-1:0];
        end
    end

`ifdef TRIG_ARB_ROUNDROBIN_EN
    always_ff @(posedge clk250_i or posedge rst_i) begin
        if (rst_i)
            r_rr_ptr <= '0;
        else if (w_issue)
            r_rr_ptr <= (w_grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : w_grant_idx + SRC_W'(1);
    end
`endif

    assign trig_o        = r_trig;
    assign trig_src_o    = r_trig_src;
    assign trig_pat_o    = r_trig_pat;
    assign buf_o         = r_buf;
    assign busy_o        = r_busy;
    assign occ_o         = r_occ;
    assign event_count_o = r_event_count;
    assign lost_count_o  = r_lost_count;
    assign clear_err_o   = r_clear_err;

endmodule
